output_argmax: RTL and testbench

OUTPUT_ARGMAX -- requirements
Module: output_argmax

---
 rtl/nn_pkg.sv | 17 +
 rtl/score_compare.sv | 20 ++
 rtl/output_argmax.sv | 172 +++++++++++++++++
 tb/tb_output_argmax.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg
//   Definitions shared by the hidden layer, the output layer and the argmax
//   stage: network geometry, the Q16.16 score format and the FSM state
//   encoding used by output_argmax.
package nn_pkg;

  localparam int NN_NUM_CLASSES = 10;  // output-layer scores per sample
  localparam int NN_DATA_WIDTH  = 32;  // bits per score
  localparam int NN_FRAC_BITS   = 16;  // Q16.16: low 16 bits are the fraction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } argmax_state_e;

endpackage

// File: rtl/score_compare.sv
// score_compare
//   Combinational signed greater-than for two-complement Q16.16 scores.
//   Ports:
//     a, b : input scores (W bits, signed)
//     gt   : 1 when a > b (strict)
module score_compare
  import nn_pkg::*;
#(
  parameter int W = NN_DATA_WIDTH
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gt
);

  // A fixed binary point does not change ordering, so a plain signed
  // integer compare is exact for Q16.16.
  assign gt = $signed(a) > $signed(b);

endmodule

// File: rtl/output_argmax.sv
// output_argmax
//   Picks the winning class from the output layer. On start the whole score
//   vector is captured, then one class per cycle is compared against the
//   running best and second-best. The result is held with a valid/ready
//   handshake and stays readable after it has been accepted.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     start      : classify the scores currently on result (honoured in IDLE)
//     result     : flattened scores, class k at [DATA_WIDTH*k +: DATA_WIDTH]
//     busy       : high while scanning or waiting for out_ready
//     out_valid  : digit/max_score/margin are valid
//     out_ready  : consumer accepts the result
//     digit      : index of the winning class (lowest index on ties)
//     max_score  : winning score
//     margin     : winning score minus second-best score
//   NUM_CLASSES must be at most 15 so that the 4-bit index can reach the
//   one-past-the-end value used to close the scan.
module output_argmax
  import nn_pkg::*;
#(
  parameter int NUM_CLASSES = NN_NUM_CLASSES,
  parameter int DATA_WIDTH  = NN_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] result,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [3:0]                        digit,
  output logic [DATA_WIDTH-1:0]             max_score,
  output logic [DATA_WIDTH-1:0]             margin
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  // Index value reached once every class has been compared; the cycle spent
  // there latches the outputs, giving a start-to-valid latency of NUM_CLASSES.
  localparam logic [3:0] SCAN_END = 4'(NUM_CLASSES);

  argmax_state_e         state_q, state_d;
  logic [3:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] bank_q [NUM_CLASSES];
  logic [DATA_WIDTH-1:0] bank_d [NUM_CLASSES];
  logic [DATA_WIDTH-1:0] best_q, best_d;
  logic [3:0]            best_idx_q, best_idx_d;
  logic [DATA_WIDTH-1:0] second_q, second_d;
  logic [3:0]            digit_q, digit_d;
  logic [DATA_WIDTH-1:0] max_score_q, max_score_d;
  logic [DATA_WIDTH-1:0] margin_q, margin_d;

  logic [DATA_WIDTH-1:0] result_score [NUM_CLASSES];
  logic [DATA_WIDTH-1:0] cand;
  logic                  cand_gt_best;
  logic                  cand_gt_second;
  logic [DATA_WIDTH:0]   margin_full;

  // Unflatten the input bus into one word per class.
  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
      assign result_score[gi] = result[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_comb begin
    cand = '0;
    if (idx_q < SCAN_END) begin
      cand = bank_q[idx_q];
    end
  end

  score_compare #(.W(DATA_WIDTH)) u_cmp_best (
    .a  (cand),
    .b  (best_q),
    .gt (cand_gt_best)
  );

  score_compare #(.W(DATA_WIDTH)) u_cmp_second (
    .a  (cand),
    .b  (second_q),
    .gt (cand_gt_second)
  );

  // One extra bit so the full signed range (e.g. 0x7FFFFFFF - 0x80000000)
  // cannot wrap; best >= second always holds, so the sign bit stays clear.
  assign margin_full = {best_q[DATA_WIDTH-1], best_q}
                     - {second_q[DATA_WIDTH-1], second_q};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bank_d      = bank_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    second_d    = second_q;
    digit_d     = digit_q;
    max_score_d = max_score_q;
    margin_d    = margin_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bank_d     = result_score;
          best_d     = result_score[0];
          best_idx_d = 4'd0;
          second_d   = MOST_NEG;
          idx_d      = 4'd1;
          state_d    = ST_SCAN;
        end
      end

      ST_SCAN: begin
        if (idx_q < SCAN_END) begin
          // Strict compare keeps the lowest index on ties.
          if (cand_gt_best) begin
            second_d   = best_q;
            best_d     = cand;
            best_idx_d = idx_q;
          end else if (cand_gt_second) begin
            second_d = cand;
          end
          idx_d = idx_q + 4'd1;
        end else begin
          digit_d     = best_idx_q;
          max_score_d = best_q;
          // Clamp instead of wrapping should the ordering invariant break.
          margin_d    = margin_full[DATA_WIDTH] ? '0 : margin_full[DATA_WIDTH-1:0];
          state_d     = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      bank_q      <= '{default: '0};
      best_q      <= '0;
      best_idx_q  <= '0;
      second_q    <= '0;
      digit_q     <= '0;
      max_score_q <= '0;
      margin_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bank_q      <= bank_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      second_q    <= second_d;
      digit_q     <= digit_d;
      max_score_q <= max_score_d;
      margin_q    <= margin_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign digit     = digit_q;
  assign max_score = max_score_q;
  assign margin    = margin_q;

endmodule

// File: tb/tb_output_argmax.sv
// tb_output_argmax
//   Randomised and directed stimulus for output_argmax. The stimulus process
//   pushes the reference model's answer into a scoreboard queue at every
//   accepted start; an independent monitor compares every cycle the DUT
//   shows out_valid and pops the entry when out_valid falls.
module tb_output_argmax;
  import nn_pkg::*;

  localparam int N = NN_NUM_CLASSES;
  localparam int W = NN_DATA_WIDTH;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [N*W-1:0] result;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [3:0]     digit;
  logic [W-1:0]   max_score;
  logic [W-1:0]   margin;

  typedef struct {
    logic [3:0]   digit;
    logic [W-1:0] max_s;
    logic [W-1:0] marg;
    int           t;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cycle = 0;
  bit           mon_prev_valid = 1'b0;
  logic [W-1:0] scores [N];

  output_argmax #(.NUM_CLASSES(N), .DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .result    (result),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digit     (digit),
    .max_score (max_score),
    .margin    (margin)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Reference: argmax with lowest index on ties; second-best is the largest
  // score among all the other classes.
  function automatic exp_t model(input logic [W-1:0] s [N], input int t);
    exp_t               e;
    int                 w;
    logic signed [W-1:0] sec;
    w = 0;
    for (int j = 1; j < N; j++)
      if ($signed(s[j]) > $signed(s[w])) w = j;
    sec = {1'b1, {(W-1){1'b0}}};
    for (int j = 0; j < N; j++)
      if (j != w && $signed(s[j]) > sec) sec = s[j];
    e.digit = 4'(w);
    e.max_s = s[w];
    e.marg  = s[w] - sec;
    e.t     = t;
    return e;
  endfunction

  task automatic pack_scores();
    for (int k = 0; k < N; k++) result[k*W +: W] = scores[k];
  endtask

  task automatic scramble_result();
    for (int k = 0; k < N; k++) result[k*W +: W] = $urandom;
  endtask

  // One classification. hold > 0: keep out_ready low for hold cycles after
  // out_valid while toggling result and holding start high, then handshake
  // with start still high.
  task automatic run_txn(input int hold);
    int   guard;
    exp_t e;
    @(negedge clk);
    guard = 0;
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("idle_before_start", busy, 0);
    pack_scores();
    start = 1'b1;
    e = model(scores, cycle + 1);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    scramble_result();
    guard = 0;
    while (!out_valid && guard < 3 * N) begin
      @(negedge clk);
      guard++;
    end
    check("valid_seen", out_valid, 1);
    if (hold > 0) begin
      out_ready = 1'b0;
      start     = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        scramble_result();
      end
      check("busy_during_hold", busy, 1);
    end else begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_after_accept", out_valid, 0);
    check("busy_after_accept", busy, 0);
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    @(posedge clk);
    #1;
    check("start_ignored_at_accept", busy, 0);
    check("digit_kept", digit, e.digit);
    check("max_kept", max_score, e.max_s);
    check("margin_kept", margin, e.marg);
  endtask

  // Monitor: compares every valid cycle against the head of the scoreboard,
  // which also covers output stability while out_ready is low.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got out_valid=1 required 0 (cycle %0d)", cycle);
        end else begin
          if (!mon_prev_valid) check("latency", 64'(cycle - sb[0].t), 64'(N));
          check("digit", digit, sb[0].digit);
          check("max_score", max_score, sb[0].max_s);
          check("margin", margin, sb[0].marg);
        end
      end else if (mon_prev_valid && sb.size() > 0) begin
        void'(sb.pop_front());
      end
      mon_prev_valid = out_valid;
    end
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    result    = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_digit", digit, 0);
    check("rst_max", max_score, 0);
    check("rst_margin", margin, 0);
    rst = 1'b0;

    // Ascending 1.0 .. 10.0: digit 9, max 0x000A0000, margin 0x00010000.
    for (int k = 0; k < N; k++) scores[k] = W'((k + 1) * 32'h0001_0000);
    run_txn(0);
    $display("txn ascending: digit=%0d max=%h margin=%h", digit, max_score, margin);

    // All -1.0: digit 0, margin 0.
    for (int k = 0; k < N; k++) scores[k] = 32'hFFFF_0000;
    run_txn(0);
    $display("txn all_neg: digit=%0d max=%h margin=%h", digit, max_score, margin);

    // Extremes: class 3 max positive, class 7 most negative.
    for (int k = 0; k < N; k++) scores[k] = '0;
    scores[3] = 32'h7FFF_FFFF;
    scores[7] = 32'h8000_0000;
    run_txn(0);
    $display("txn extremes: digit=%0d max=%h margin=%h", digit, max_score, margin);

    // Same with class 3 zeroed: tie at 0 goes to class 0.
    scores[3] = '0;
    run_txn(0);
    $display("txn tie_zero: digit=%0d max=%h margin=%h", digit, max_score, margin);

    // Back-pressure for 5 cycles with result and start toggling.
    for (int k = 0; k < N; k++) scores[k] = $urandom;
    run_txn(5);
    $display("txn hold: digit=%0d max=%h margin=%h", digit, max_score, margin);

    // Reset 4 cycles into a scan: aborts, outputs cleared, no valid pulse.
    @(negedge clk);
    for (int k = 0; k < N; k++) scores[k] = $urandom;
    pack_scores();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_digit", digit, 0);
    check("abort_max", max_score, 0);
    check("abort_margin", margin, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * N) @(negedge clk);
    check("abort_still_idle", busy, 0);
    $display("txn reset_abort: busy=%0d out_valid=%0d", busy, out_valid);
    for (int k = 0; k < N; k++) scores[k] = W'((k + 1) * 32'h0001_0000);
    run_txn(0);
    $display("txn after_abort: digit=%0d max=%h margin=%h", digit, max_score, margin);

    // Random mix: full-range words, and small values that provoke ties.
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < N; k++) begin
        if (t % 2 == 0) scores[k] = $urandom;
        else            scores[k] = W'($signed($urandom_range(0, 4)) - 2) << 16;
      end
      run_txn((t % 7 == 3) ? 2 : 0);
      $display("txn rand%0d: digit=%0d max=%h margin=%h", t, digit, max_score, margin);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
